us_replicate: RTL and testbench

US_REPLICATE -- requirements
Module: us_replicate

---
 rtl/us_replicate.sv | 154 +++++++++++++++
 tb/tb_us_replicate.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/us_replicate.sv
// us_replicate: SCALE-times horizontal and vertical pixel replication of a decimated video stream.
// Optional US_ZERO_BLANK_EN forces output data to zero while o_de is low.
module us_replicate #(
    parameter int WIDTH = 10,
    parameter int HACT  = 10,
    parameter int SCALE = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_de,
    input  logic [WIDTH-1:0] i_r_data,
    input  logic [WIDTH-1:0] i_g_data,
    input  logic [WIDTH-1:0] i_b_data,
    output logic             o_vsync,
    output logic             o_hsync,
    output logic             o_de,
    output logic [WIDTH-1:0] o_r_data,
    output logic [WIDTH-1:0] o_g_data,
    output logic [WIDTH-1:0] o_b_data
);
    localparam int DEPTH = (HACT + SCALE - 1) / SCALE;
    localparam int AW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(HACT + 1);
    localparam int CW    = 16;
    localparam int RW    = 2;
    localparam int PW    = 3 * WIDTH;
    localparam logic [1:0] WAIT = 2'd0, CAPT = 2'd1, REP = 2'd2;

    logic [PW-1:0] mem [DEPTH];
    logic          vs_q, hs_q, de_q, vs_rise, hs_rise, de_rise;
    logic [1:0]    state_q, state_d;
    logic          armed_q, armed_d, line_de_q, line_de_d, src_q, src_d, ode_q, ode_d;
    logic [CW-1:0] hcnt_q, hcnt_d, off_q, off_d;
    logic [AW-1:0] waddr_q, waddr_d, ra;
    logic [RW-1:0] rep_q, rep_d;
    logic [IW-1:0] win_q, win_d, idx;
    logic [PW-1:0] last_q, last_d, opix_q, opix_d, pix, dsel;
    logic          cap, we, start, start_rep, run;

    always_comb begin
        vs_rise   = i_vsync & ~vs_q;
        hs_rise   = i_hsync & ~hs_q;
        de_rise   = i_de & ~de_q;
        pix       = {i_r_data, i_g_data, i_b_data};
        hcnt_d    = (hs_rise || vs_rise) ? '0 : (&hcnt_q) ? hcnt_q : hcnt_q + 1'b1;
        state_d   = state_q;
        armed_d   = armed_q | vs_rise;
        off_d     = off_q;
        waddr_d   = waddr_q;
        rep_d     = rep_q;
        line_de_d = line_de_q;
        last_d    = last_q;
        cap       = 1'b0;
        start     = 1'b0;
        start_rep = 1'b0;
        if (vs_rise) begin
            state_d   = WAIT;
            off_d     = '0;
            waddr_d   = '0;
            rep_d     = '0;
            line_de_d = 1'b0;
        end else if (state_q == WAIT) begin
            if (armed_q && de_rise) begin
                state_d = CAPT;
                off_d   = hcnt_d;
                cap     = 1'b1;
            end
        end else if (state_q == CAPT) begin
            if (hs_rise) begin
                state_d   = line_de_q ? REP : WAIT;
                rep_d     = RW'(1);
                waddr_d   = '0;
                line_de_d = 1'b0;
            end else begin
                cap = i_de;
            end
        end else if (hs_rise) begin
            state_d = (rep_q == RW'(SCALE - 1)) ? CAPT : REP;
            rep_d   = rep_q + 1'b1;
            waddr_d = '0;
        end else begin
            start_rep = (hcnt_d == off_q);
        end
        // writes past the last entry are dropped; the address saturates there
        we = cap && (waddr_q < AW'(DEPTH));
        if (we) waddr_d = waddr_q + 1'b1;
        if (cap) begin
            last_d    = pix;
            start     = !line_de_q;
            line_de_d = 1'b1;
        end
        run   = start || start_rep;
        ode_d = !vs_rise && (run || win_q != '0);
        win_d = vs_rise ? '0 : run ? IW'(HACT - 1) : (win_q != '0) ? win_q - 1'b1 : '0;
        src_d = start_rep || (!start && src_q);
        idx   = start_rep ? '0 : IW'(HACT) - win_q;
        ra    = AW'(idx / IW'(SCALE));
        dsel  = src_d ? mem[ra] : (i_de ? pix : last_q);
`ifdef US_ZERO_BLANK_EN
        opix_d = ode_d ? dsel : '0;
`else
        opix_d = ode_d ? dsel : opix_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr_q] <= pix;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_q      <= 1'b0;
            hs_q      <= 1'b0;
            de_q      <= 1'b0;
            state_q   <= WAIT;
            armed_q   <= 1'b0;
            line_de_q <= 1'b0;
            src_q     <= 1'b0;
            ode_q     <= 1'b0;
            hcnt_q    <= '0;
            off_q     <= '0;
            waddr_q   <= '0;
            rep_q     <= '0;
            win_q     <= '0;
            last_q    <= '0;
            opix_q    <= '0;
        end else begin
            vs_q      <= i_vsync;
            hs_q      <= i_hsync;
            de_q      <= i_de;
            state_q   <= state_d;
            armed_q   <= armed_d;
            line_de_q <= line_de_d;
            src_q     <= src_d;
            ode_q     <= ode_d;
            hcnt_q    <= hcnt_d;
            off_q     <= off_d;
            waddr_q   <= waddr_d;
            rep_q     <= rep_d;
            win_q     <= win_d;
            last_q    <= last_d;
            opix_q    <= opix_d;
        end
    end

    assign o_vsync  = vs_q;
    assign o_hsync  = hs_q;
    assign o_de     = ode_q;
    assign o_r_data = opix_q[PW-1 -: WIDTH];
    assign o_g_data = opix_q[2*WIDTH-1 -: WIDTH];
    assign o_b_data = opix_q[WIDTH-1:0];
endmodule

// File: tb/tb_us_replicate.sv
// tb_us_replicate: directed line sequence for us_replicate with a cycle-stamped expected-output queue.
module tb_us_replicate;
    localparam int WIDTH = 10;
    localparam int HACT  = 10;
    localparam int SCALE = 2;
    localparam int LINE  = 30;
`ifdef US_ZERO_BLANK_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic       de;
        logic [9:0] r;
        logic [9:0] g;
    } exp_t;

    logic             clk, rstn;
    logic             i_vsync, i_hsync, i_de;
    logic [WIDTH-1:0] i_r_data, i_g_data, i_b_data;
    logic             o_vsync, o_hsync, o_de;
    logic [WIDTH-1:0] o_r_data, o_g_data, o_b_data;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];

    us_replicate #(.WIDTH(WIDTH), .HACT(HACT), .SCALE(SCALE)) dut (
        .clk(clk), .rstn(rstn),
        .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
        .i_r_data(i_r_data), .i_g_data(i_g_data), .i_b_data(i_b_data),
        .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
        .o_r_data(o_r_data), .o_g_data(o_g_data), .o_b_data(o_b_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic de, input int r);
        exp_t e;
        e.cyc = c;
        e.de  = de;
        e.r   = 10'(r);
        e.g   = 10'(r + 100);
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("sb_de", 64'(o_de), 64'(e.de));
            if (e.de) begin
                chk("sb_r", 64'(o_r_data), 64'(e.r));
                chk("sb_g", 64'(o_g_data), 64'(e.g));
            end
        end
    endtask

    // One line: hsync on k=0..1, optional i_de on k=3,5,..,11 carrying r0..r0+4.
    // exp0>0 means n_exp output pixels exp0,exp0,exp0+1,... starting the cycle after k=3.
    task automatic run_line(input int r0, input bit de_en, input int exp0, input int n_exp,
                            input int vs_k, input int rst_k);
        logic [9:0] r;
        bit         rst;
        for (int k = 0; k < LINE; k++) begin
            i_hsync  = (k < 2);
            i_vsync  = (vs_k >= 0) && (k == vs_k || k == vs_k + 1);
            i_de     = de_en && k >= 3 && k <= 11 && (k % 2 == 1);
            r        = i_de ? 10'(r0 + (k - 3) / 2) : 10'($urandom);
            i_r_data = r;
            i_g_data = r + 10'd100;
            i_b_data = r + 10'd200;
            rst      = (rst_k >= 0) && k >= rst_k && k < rst_k + 2;
            rstn     = !rst;
            if (k == 3) begin
                chk("pre_de", 64'(o_de), 64'(0));
                if (exp0 > 0) begin
                    for (int j = 0; j < n_exp; j++) push(cyc + 1 + j, 1'b1, exp0 + j / 2);
                    push(cyc + 1 + n_exp, 1'b0, 0);
                end else begin
                    push(cyc + 1, 1'b0, 0);
                    push(cyc + 6, 1'b0, 0);
                end
            end
            if (k == 20 && exp0 > 0 && n_exp == HACT)
                chk("blank_r", 64'(o_r_data), ZB ? 64'(0) : 64'(exp0 + 4));
            tick();
            chk("hsync_dly", 64'(o_hsync), 64'((k < 2) && !rst));
            chk("vsync_dly", 64'(o_vsync), 64'(i_vsync && !rst));
            if (rst) chk("rst_mid", 64'({o_de, o_r_data, o_g_data, o_b_data}), 64'(0));
        end
    endtask

    initial begin
        rstn     = 1'b0;
        i_vsync  = 1'b0;
        i_hsync  = 1'b0;
        i_de     = 1'b0;
        i_r_data = '0;
        i_g_data = '0;
        i_b_data = '0;
        repeat (6) begin
            i_vsync  = 1'($urandom);
            i_hsync  = 1'($urandom);
            i_de     = 1'($urandom);
            i_r_data = 10'($urandom);
            i_g_data = 10'($urandom);
            i_b_data = 10'($urandom);
            tick();
            chk("rst_out", 64'({o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data}), 64'(0));
        end
        run_line(1, 1'b1, 0, 0, -1, -1);
        run_line(0, 1'b0, 0, 0, 5, -1);
        run_line(1, 1'b1, 1, HACT, -1, -1);
        run_line(0, 1'b0, 1, HACT, -1, -1);
        run_line(6, 1'b1, 6, HACT, -1, -1);
        run_line(0, 1'b0, 6, HACT, -1, -1);
        run_line(0, 1'b0, 0, 0, -1, -1);
        run_line(0, 1'b0, 0, 0, -1, -1);
        run_line(11, 1'b1, 11, HACT, -1, -1);
        run_line(0, 1'b0, 11, 4, 7, -1);
        run_line(20, 1'b1, 20, HACT, -1, -1);
        run_line(0, 1'b0, 20, HACT, -1, -1);
        run_line(30, 1'b1, 30, 3, -1, 6);
        run_line(0, 1'b0, 0, 0, -1, -1);
        run_line(40, 1'b1, 0, 0, -1, -1);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
